// File: rtl/draw_text_box.sv
// Text overlay stage: 32x8 character window of 8x16 glyphs composited onto the pixel stream.
// Optional BG_FILL_EN: clear glyph pixels inside the window take BG_COLOR instead of rgb_in.
module draw_text_box #(
    parameter int unsigned XPOS       = 48,
    parameter int unsigned YPOS       = 64,
    parameter logic [11:0] TEXT_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [7:0]  char_xy,
    input  logic [7:0]  char_code,
    output logic [3:0]  char_line,
    input  logic [7:0]  char_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } timing_t;

    localparam int unsigned DELAY = 3;

    localparam logic [11:0] X_LO = 12'(XPOS);
    localparam logic [11:0] X_HI = 12'(XPOS + 256);
    localparam logic [11:0] Y_LO = 12'(YPOS);
    localparam logic [11:0] Y_HI = 12'(YPOS + 128);

`ifdef BG_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif

    // Only the low offset bits feed the address, so the subtraction is done at that width.
    logic [7:0] rel_x;
    logic [6:0] rel_y;
    logic       in_box;
    logic [11:0] h12;
    logic [11:0] v12;

    assign rel_x = hcount_in[7:0] - 8'(XPOS);
    assign rel_y = vcount_in[6:0] - 7'(YPOS);
    assign h12   = {1'b0, hcount_in};
    assign v12   = {1'b0, vcount_in};
    assign in_box = (h12 >= X_LO) && (h12 < X_HI) && (v12 >= Y_LO) && (v12 < Y_HI);

    timing_t    tim_d   [DELAY];
    logic [2:0] xoff_d  [DELAY];
    logic       inbox_d [DELAY];

    timing_t    tim_now;
    logic       glyph_bit;
    logic [11:0] rgb_next;

    assign tim_now = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    // bit 7 of the font row is the leftmost pixel, so index with the inverted offset
    assign glyph_bit = char_pixels[~xoff_d[DELAY-1]];

    always_comb begin
        rgb_next = tim_d[DELAY-1].rgb;
        if (inbox_d[DELAY-1]) begin
            if (glyph_bit)
                rgb_next = TEXT_COLOR;
            else if (FILL_EN)
                rgb_next = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy    <= '0;
            char_line  <= '0;
            for (int unsigned i = 0; i < DELAY; i++) begin
                tim_d[i]   <= '0;
                xoff_d[i]  <= '0;
                inbox_d[i] <= 1'b0;
            end
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            char_xy    <= {rel_y[6:4], rel_x[7:3]};
            char_line  <= rel_y[3:0];

            tim_d[0]   <= tim_now;
            xoff_d[0]  <= rel_x[2:0];
            inbox_d[0] <= in_box;
            for (int unsigned i = 1; i < DELAY; i++) begin
                tim_d[i]   <= tim_d[i-1];
                xoff_d[i]  <= xoff_d[i-1];
                inbox_d[i] <= inbox_d[i-1];
            end

            hcount_out <= tim_d[DELAY-1].hcount;
            vcount_out <= tim_d[DELAY-1].vcount;
            hsync_out  <= tim_d[DELAY-1].hsync;
            vsync_out  <= tim_d[DELAY-1].vsync;
            hblnk_out  <= tim_d[DELAY-1].hblnk;
            vblnk_out  <= tim_d[DELAY-1].vblnk;
            rgb_out    <= rgb_next;
        end
    end

endmodule
